// File: rtl/id_issue_stage.sv
// Decode/issue stage: turns an RV32I OP, OP-IMM, LUI, AUIPC or BRANCH instruction
// into an ALU bundle (operands, control, destination) held in the ID/EX register.
module id_issue_stage #(
    parameter int          XLEN     = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [31:0]     if_inst_i,
    input  logic [XLEN-1:0] if_pc_i,
    input  logic            if_valid_i,
    output logic            id_ready_o,
    input  logic            stall_i,
    input  logic            flush_i,
    output logic [4:0]      rs1_raddr_o,
    output logic [4:0]      rs2_raddr_o,
    input  logic [XLEN-1:0] rs1_rdata_i,
    input  logic [XLEN-1:0] rs2_rdata_i,
    input  logic            fwd_we_i,
    input  logic [4:0]      fwd_waddr_i,
    input  logic [XLEN-1:0] fwd_wdata_i,
    output logic [XLEN-1:0] id_ex_reg_op_a_o,
    output logic [XLEN-1:0] id_ex_reg_op_b_o,
    output logic [4:0]      id_ex_reg_ALUctrl_o,
    output logic [4:0]      id_ex_reg_reg_waddr_o,
    output logic            id_ex_reg_reg_we_o,
    output logic            id_ex_valid_o,
    output logic            illegal_inst_o
);

    typedef enum logic [4:0] {
        ALU_NO_OP = 5'd0,
        ALU_ADD   = 5'd1,
        ALU_SUB   = 5'd2,
        ALU_EQU   = 5'd3,
        ALU_NEQ   = 5'd4,
        ALU_SLT   = 5'd5,
        ALU_SGE   = 5'd6,
        ALU_SLTU  = 5'd7,
        ALU_SGEU  = 5'd8,
        ALU_XOR   = 5'd9,
        ALU_OR    = 5'd10,
        ALU_AND   = 5'd11,
        ALU_SLL   = 5'd12,
        ALU_SRL   = 5'd13,
        ALU_SRA   = 5'd14
    } alu_ctrl_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] shamt;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    alu_ctrl_e       dec_ctrl;
    logic [XLEN-1:0] dec_op_a;
    logic [XLEN-1:0] dec_op_b;
    logic            dec_we;
    logic            dec_illegal;
    logic            unused_reset_pc;

    assign unused_reset_pc = ^RESET_PC;

    assign opcode = if_inst_i[6:0];
    assign rd     = if_inst_i[11:7];
    assign funct3 = if_inst_i[14:12];
    assign rs1    = if_inst_i[19:15];
    assign rs2    = if_inst_i[24:20];
    assign funct7 = if_inst_i[31:25];

    assign imm_i = XLEN'(signed'(if_inst_i[31:20]));
    assign imm_u = XLEN'(signed'({if_inst_i[31:12], 12'h000}));
    assign shamt = XLEN'(if_inst_i[24:20]);

    assign rs1_raddr_o = rs1;
    assign rs2_raddr_o = rs2;
    assign id_ready_o  = !stall_i;

    // x0 reads as zero even if a writeback to x0 is in flight.
    assign rs1_val = (rs1 == 5'd0) ? '0 :
                     (fwd_we_i && fwd_waddr_i == rs1) ? fwd_wdata_i : rs1_rdata_i;
    assign rs2_val = (rs2 == 5'd0) ? '0 :
                     (fwd_we_i && fwd_waddr_i == rs2) ? fwd_wdata_i : rs2_rdata_i;

    function automatic alu_ctrl_e arith_ctrl(input logic [2:0] f3);
        alu_ctrl_e c;
        case (f3)
            3'd0: c = ALU_ADD;
            3'd1: c = ALU_SLL;
            3'd2: c = ALU_SLT;
            3'd3: c = ALU_SLTU;
            3'd4: c = ALU_XOR;
            3'd5: c = ALU_SRL;
            3'd6: c = ALU_OR;
            3'd7: c = ALU_AND;
        endcase
        return c;
    endfunction

    always_comb begin
        dec_ctrl    = ALU_NO_OP;
        dec_op_a    = '0;
        dec_op_b    = '0;
        dec_we      = 1'b0;
        dec_illegal = 1'b0;
        case (opcode)
            OPC_OP: begin
                dec_op_a = rs1_val;
                dec_op_b = rs2_val;
                dec_we   = 1'b1;
                if (funct7 == 7'h00)
                    dec_ctrl = arith_ctrl(funct3);
                else if (funct7 == 7'h20 && funct3 == 3'd0)
                    dec_ctrl = ALU_SUB;
                else if (funct7 == 7'h20 && funct3 == 3'd5)
                    dec_ctrl = ALU_SRA;
                else
                    dec_illegal = 1'b1;
            end
            OPC_OP_IMM: begin
                dec_op_a = rs1_val;
                dec_op_b = imm_i;
                dec_we   = 1'b1;
                dec_ctrl = arith_ctrl(funct3);
                // Shift-immediates reuse inst[31:25] as a sub-opcode.
                if (funct3 == 3'd1) begin
                    dec_op_b = shamt;
                    if (funct7 != 7'h00)
                        dec_illegal = 1'b1;
                end else if (funct3 == 3'd5) begin
                    dec_op_b = shamt;
                    if (funct7 == 7'h20)
                        dec_ctrl = ALU_SRA;
                    else if (funct7 != 7'h00)
                        dec_illegal = 1'b1;
                end
            end
            OPC_LUI: begin
                dec_op_b = imm_u;
                dec_ctrl = ALU_ADD;
                dec_we   = 1'b1;
            end
            OPC_AUIPC: begin
                dec_op_a = if_pc_i;
                dec_op_b = imm_u;
                dec_ctrl = ALU_ADD;
                dec_we   = 1'b1;
            end
            OPC_BRANCH: begin
                dec_op_a = rs1_val;
                dec_op_b = rs2_val;
                case (funct3)
                    3'd0:    dec_ctrl = ALU_EQU;
                    3'd1:    dec_ctrl = ALU_NEQ;
                    3'd4:    dec_ctrl = ALU_SLT;
                    3'd5:    dec_ctrl = ALU_SGE;
                    3'd6:    dec_ctrl = ALU_SLTU;
                    3'd7:    dec_ctrl = ALU_SGEU;
                    default: dec_illegal = 1'b1;
                endcase
            end
            default: dec_illegal = 1'b1;
        endcase
        if (dec_illegal) begin
            dec_ctrl = ALU_NO_OP;
            dec_op_a = '0;
            dec_op_b = '0;
            dec_we   = 1'b0;
        end
        if (rd == 5'd0)
            dec_we = 1'b0;
    end

    // Flush beats stall; a stall holds whatever was captured, operands included.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_ex_reg_op_a_o      <= '0;
            id_ex_reg_op_b_o      <= '0;
            id_ex_reg_ALUctrl_o   <= ALU_NO_OP;
            id_ex_reg_reg_waddr_o <= '0;
            id_ex_reg_reg_we_o    <= 1'b0;
            id_ex_valid_o         <= 1'b0;
            illegal_inst_o        <= 1'b0;
        end else if (flush_i || (!stall_i && !if_valid_i)) begin
            id_ex_reg_op_a_o      <= '0;
            id_ex_reg_op_b_o      <= '0;
            id_ex_reg_ALUctrl_o   <= ALU_NO_OP;
            id_ex_reg_reg_waddr_o <= '0;
            id_ex_reg_reg_we_o    <= 1'b0;
            id_ex_valid_o         <= 1'b0;
            illegal_inst_o        <= 1'b0;
        end else if (!stall_i) begin
            id_ex_reg_op_a_o      <= dec_op_a;
            id_ex_reg_op_b_o      <= dec_op_b;
            id_ex_reg_ALUctrl_o   <= dec_ctrl;
            id_ex_reg_reg_waddr_o <= rd;
            id_ex_reg_reg_we_o    <= dec_we;
            id_ex_valid_o         <= 1'b1;
            illegal_inst_o        <= dec_illegal;
        end
    end

endmodule

// File: tb/tb_id_issue_stage.sv
// Bench for id_issue_stage: directed vector table, hazard-control sequences and
// randomized instructions whose expected bundle is known from how they were built.
module tb_id_issue_stage;

    localparam logic [6:0] OP    = 7'b0110011;
    localparam logic [6:0] OPIMM = 7'b0010011;
    localparam logic [6:0] LUI   = 7'b0110111;
    localparam logic [6:0] AUIPC = 7'b0010111;
    localparam logic [6:0] BR    = 7'b1100011;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  ctrl;
        logic [4:0]  waddr;
        logic        we;
        logic        valid;
        logic        ill;
    } bundle_t;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] rs1d;
        logic [31:0] rs2d;
        logic        fwe;
        logic [4:0]  fwa;
        logic [31:0] fwd;
        bundle_t     exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] if_inst_i;
    logic [31:0] if_pc_i;
    logic        if_valid_i;
    logic        id_ready_o;
    logic        stall_i;
    logic        flush_i;
    logic [4:0]  rs1_raddr_o;
    logic [4:0]  rs2_raddr_o;
    logic [31:0] rs1_rdata_i;
    logic [31:0] rs2_rdata_i;
    logic        fwd_we_i;
    logic [4:0]  fwd_waddr_i;
    logic [31:0] fwd_wdata_i;
    logic [31:0] id_ex_reg_op_a_o;
    logic [31:0] id_ex_reg_op_b_o;
    logic [4:0]  id_ex_reg_ALUctrl_o;
    logic [4:0]  id_ex_reg_reg_waddr_o;
    logic        id_ex_reg_reg_we_o;
    logic        id_ex_valid_o;
    logic        illegal_inst_o;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    id_issue_stage dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .if_inst_i             (if_inst_i),
        .if_pc_i               (if_pc_i),
        .if_valid_i            (if_valid_i),
        .id_ready_o            (id_ready_o),
        .stall_i               (stall_i),
        .flush_i               (flush_i),
        .rs1_raddr_o           (rs1_raddr_o),
        .rs2_raddr_o           (rs2_raddr_o),
        .rs1_rdata_i           (rs1_rdata_i),
        .rs2_rdata_i           (rs2_rdata_i),
        .fwd_we_i              (fwd_we_i),
        .fwd_waddr_i           (fwd_waddr_i),
        .fwd_wdata_i           (fwd_wdata_i),
        .id_ex_reg_op_a_o      (id_ex_reg_op_a_o),
        .id_ex_reg_op_b_o      (id_ex_reg_op_b_o),
        .id_ex_reg_ALUctrl_o   (id_ex_reg_ALUctrl_o),
        .id_ex_reg_reg_waddr_o (id_ex_reg_reg_waddr_o),
        .id_ex_reg_reg_we_o    (id_ex_reg_reg_we_o),
        .id_ex_valid_o         (id_ex_valid_o),
        .illegal_inst_o        (illegal_inst_o)
    );

    function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                          logic [2:0] f3, logic [4:0] rd, logic [6:0] op);
        return {f7, rs2, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                          logic [4:0] rd, logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_b(logic [4:0] rs2, logic [4:0] rs1, logic [2:0] f3);
        return {7'd0, rs2, rs1, f3, 5'd0, BR};
    endfunction

    function automatic bundle_t mkb(logic [31:0] a, logic [31:0] b, logic [4:0] ctrl,
                                    logic [4:0] wa, logic we, logic ill);
        bundle_t r;
        r.a = a; r.b = b; r.ctrl = ctrl; r.waddr = wa;
        r.we = we; r.valid = 1'b1; r.ill = ill;
        return r;
    endfunction

    // Operand value a correct decoder must present for source register rs.
    function automatic logic [31:0] opnd(logic [4:0] rs, logic [31:0] rdata, logic fwe,
                                         logic [4:0] fwa, logic [31:0] fwd);
        if (rs == 5'd0) return 32'd0;
        if (fwe && fwa == rs) return fwd;
        return rdata;
    endfunction

    function automatic logic is_legal_opcode(logic [6:0] op);
        return op == OP || op == OPIMM || op == LUI || op == AUIPC || op == BR;
    endfunction

    task automatic applyStimulus(input logic [31:0] inst, input logic [31:0] pc,
                                 input logic valid, input logic stall, input logic flush,
                                 input logic [31:0] rs1d, input logic [31:0] rs2d,
                                 input logic fwe, input logic [4:0] fwa, input logic [31:0] fwd);
        if_inst_i   = inst;
        if_pc_i     = pc;
        if_valid_i  = valid;
        stall_i     = stall;
        flush_i     = flush;
        rs1_rdata_i = rs1d;
        rs2_rdata_i = rs2d;
        fwd_we_i    = fwe;
        fwd_waddr_i = fwa;
        fwd_wdata_i = fwd;
    endtask

    task automatic checkOutput(input bundle_t exp, input string name);
        bundle_t act;
        act = {id_ex_reg_op_a_o, id_ex_reg_op_b_o, id_ex_reg_ALUctrl_o, id_ex_reg_reg_waddr_o,
               id_ex_reg_reg_we_o, id_ex_valid_o, illegal_inst_o};
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: actual a=%h b=%h ctrl=%0d wa=%0d we=%b v=%b ill=%b, required a=%h b=%h ctrl=%0d wa=%0d we=%b v=%b ill=%b",
                     name, act.a, act.b, act.ctrl, act.waddr, act.we, act.valid, act.ill,
                     exp.a, exp.b, exp.ctrl, exp.waddr, exp.we, exp.valid, exp.ill);
        end
    endtask

    task automatic checkScalar(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: actual %h, required %h", name, act, exp);
        end
    endtask

    // Builds a random instruction and, from the choices made, the bundle it must produce.
    task automatic genRandom(output logic [31:0] inst, output logic [31:0] pc,
                             output logic [31:0] rs1d, output logic [31:0] rs2d,
                             output logic fwe, output logic [4:0] fwa, output logic [31:0] fwd,
                             output bundle_t exp);
        logic [4:0]  rs1, rs2, rd, c;
        logic [2:0]  f3;
        logic [6:0]  f7, op;
        logic [31:0] r, a1, a2;
        int          kind, idx;
        rs1  = 5'($urandom_range(0, 7));
        rs2  = 5'($urandom_range(0, 7));
        rd   = 5'($urandom_range(0, 7));
        rs1d = $urandom;
        rs2d = $urandom;
        fwe  = 1'($urandom_range(0, 1));
        idx  = $urandom_range(0, 2);
        fwa  = (idx == 0) ? rs1 : (idx == 1) ? rs2 : 5'($urandom_range(0, 7));
        fwd  = $urandom;
        r    = $urandom;
        pc   = {r[31:2], 2'b00};
        a1   = opnd(rs1, rs1d, fwe, fwa, fwd);
        a2   = opnd(rs2, rs2d, fwe, fwa, fwd);
        r    = $urandom;
        kind = $urandom_range(0, 5);
        case (kind)
            0: begin
                idx = $urandom_range(0, 9);
                f7 = (idx >= 8) ? 7'h20 : 7'h00;
                case (idx)
                    0: begin f3 = 3'd0; c = 5'd1;  end
                    1: begin f3 = 3'd1; c = 5'd12; end
                    2: begin f3 = 3'd2; c = 5'd5;  end
                    3: begin f3 = 3'd3; c = 5'd7;  end
                    4: begin f3 = 3'd4; c = 5'd9;  end
                    5: begin f3 = 3'd5; c = 5'd13; end
                    6: begin f3 = 3'd6; c = 5'd10; end
                    7: begin f3 = 3'd7; c = 5'd11; end
                    8: begin f3 = 3'd0; c = 5'd2;  end
                    default: begin f3 = 3'd5; c = 5'd14; end
                endcase
                inst = enc_r(f7, rs2, rs1, f3, rd, OP);
                exp  = mkb(a1, a2, c, rd, rd != 5'd0, 1'b0);
            end
            1: begin
                idx = $urandom_range(0, 5);
                case (idx)
                    0: begin f3 = 3'd0; c = 5'd1;  end
                    1: begin f3 = 3'd2; c = 5'd5;  end
                    2: begin f3 = 3'd3; c = 5'd7;  end
                    3: begin f3 = 3'd4; c = 5'd9;  end
                    4: begin f3 = 3'd6; c = 5'd10; end
                    default: begin f3 = 3'd7; c = 5'd11; end
                endcase
                inst = enc_i(r[11:0], rs1, f3, rd, OPIMM);
                exp  = mkb(a1, {{20{r[11]}}, r[11:0]}, c, rd, rd != 5'd0, 1'b0);
            end
            2: begin
                idx = $urandom_range(0, 2);
                f3 = (idx == 0) ? 3'd1 : 3'd5;
                f7 = (idx == 2) ? 7'h20 : 7'h00;
                c  = (idx == 0) ? 5'd12 : (idx == 1) ? 5'd13 : 5'd14;
                inst = enc_r(f7, r[4:0], rs1, f3, rd, OPIMM);
                exp  = mkb(a1, {27'd0, r[4:0]}, c, rd, rd != 5'd0, 1'b0);
            end
            3: begin
                if (r[0]) begin
                    inst = {r[31:12], rd, LUI};
                    exp  = mkb(32'd0, {r[31:12], 12'h000}, 5'd1, rd, rd != 5'd0, 1'b0);
                end else begin
                    inst = {r[31:12], rd, AUIPC};
                    exp  = mkb(pc, {r[31:12], 12'h000}, 5'd1, rd, rd != 5'd0, 1'b0);
                end
            end
            4: begin
                idx = $urandom_range(0, 5);
                case (idx)
                    0: begin f3 = 3'd0; c = 5'd3; end
                    1: begin f3 = 3'd1; c = 5'd4; end
                    2: begin f3 = 3'd4; c = 5'd5; end
                    3: begin f3 = 3'd5; c = 5'd6; end
                    4: begin f3 = 3'd6; c = 5'd7; end
                    default: begin f3 = 3'd7; c = 5'd8; end
                endcase
                inst = enc_r(r[6:0], rs2, rs1, f3, rd, BR);
                exp  = mkb(a1, a2, c, rd, 1'b0, 1'b0);
            end
            default: begin
                idx = $urandom_range(0, 3);
                case (idx)
                    0: begin
                        op = r[6:0];
                        while (is_legal_opcode(op)) begin
                            r  = $urandom;
                            op = r[6:0];
                        end
                        r    = $urandom;
                        inst = {r[31:12], rd, op};
                    end
                    1: begin
                        f7 = r[6:0];
                        f3 = r[9:7];
                        while (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) begin
                            r  = $urandom;
                            f7 = r[6:0];
                            f3 = r[9:7];
                        end
                        inst = enc_r(f7, rs2, rs1, f3, rd, OP);
                    end
                    2: inst = enc_r(r[6:0], rs2, rs1, r[8] ? 3'd3 : 3'd2, rd, BR);
                    default: begin
                        f3 = r[8] ? 3'd5 : 3'd1;
                        f7 = r[6:0];
                        while (f7 == 7'h00 || (f3 == 3'd5 && f7 == 7'h20)) begin
                            r  = $urandom;
                            f7 = r[6:0];
                        end
                        inst = enc_r(f7, r[24:20], rs1, f3, rd, OPIMM);
                    end
                endcase
                exp = mkb(32'd0, 32'd0, 5'd0, rd, 1'b0, 1'b1);
            end
        endcase
    endtask

    vec_t        vecs[$];
    bundle_t     exp_q, cap;
    bundle_t     add_b;
    logic [31:0] g_inst, g_pc, g_rs1d, g_rs2d, g_fwd;
    logic [4:0]  g_fwa;
    logic        g_fwe, g_v, g_st, g_fl;

    initial begin
        // Directed decode vectors: inst, pc, rs1d, rs2d, fwd_we, fwd_waddr, fwd_wdata, expected.
        vecs.push_back('{enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3, OP), 32'h0, 32'd5, 32'd7, 1'b0, 5'd0, 32'd0,
                         mkb(32'd5, 32'd7, 5'd1, 5'd3, 1'b1, 1'b0)});
        vecs.push_back('{enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd3, OP), 32'h0, 32'd5, 32'd7, 1'b0, 5'd0, 32'd0,
                         mkb(32'd5, 32'd7, 5'd2, 5'd3, 1'b1, 1'b0)});
        vecs.push_back('{enc_i(12'h403, 5'd4, 3'd5, 5'd4, OPIMM), 32'h0, 32'hF000_0000, 32'd0, 1'b0, 5'd0, 32'd0,
                         mkb(32'hF000_0000, 32'd3, 5'd14, 5'd4, 1'b1, 1'b0)});
        vecs.push_back('{{20'h12345, 5'd5, LUI}, 32'h0, 32'd1, 32'd2, 1'b0, 5'd0, 32'd0,
                         mkb(32'd0, 32'h1234_5000, 5'd1, 5'd5, 1'b1, 1'b0)});
        vecs.push_back('{{20'h00001, 5'd1, AUIPC}, 32'h100, 32'd1, 32'd2, 1'b0, 5'd0, 32'd0,
                         mkb(32'h100, 32'h1000, 5'd1, 5'd1, 1'b1, 1'b0)});
        vecs.push_back('{enc_b(5'd2, 5'd1, 3'd5), 32'h0, 32'hFFFF_FFFF, 32'd1, 1'b0, 5'd0, 32'd0,
                         mkb(32'hFFFF_FFFF, 32'd1, 5'd6, 5'd0, 1'b0, 1'b0)});
        vecs.push_back('{enc_i(12'd1, 5'd1, 3'd0, 5'd0, OPIMM), 32'h0, 32'd10, 32'd0, 1'b0, 5'd0, 32'd0,
                         mkb(32'd10, 32'd1, 5'd1, 5'd0, 1'b0, 1'b0)});
        vecs.push_back('{enc_r(7'h00, 5'd7, 5'd7, 3'd0, 5'd6, OP), 32'h0, 32'd1, 32'd1, 1'b1, 5'd7, 32'd9,
                         mkb(32'd9, 32'd9, 5'd1, 5'd6, 1'b1, 1'b0)});
        vecs.push_back('{enc_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd6, OP), 32'h0, 32'd5, 32'd5, 1'b1, 5'd0, 32'd9,
                         mkb(32'd0, 32'd0, 5'd1, 5'd6, 1'b1, 1'b0)});
        vecs.push_back('{32'h0000_0000, 32'h0, 32'd5, 32'd5, 1'b0, 5'd0, 32'd0,
                         mkb(32'd0, 32'd0, 5'd0, 5'd0, 1'b0, 1'b1)});
        vecs.push_back('{enc_r(7'h01, 5'd2, 5'd1, 3'd0, 5'd3, OP), 32'h0, 32'd5, 32'd7, 1'b0, 5'd0, 32'd0,
                         mkb(32'd0, 32'd0, 5'd0, 5'd3, 1'b0, 1'b1)});
        vecs.push_back('{enc_i(12'h401, 5'd1, 3'd1, 5'd3, OPIMM), 32'h0, 32'd5, 32'd7, 1'b0, 5'd0, 32'd0,
                         mkb(32'd0, 32'd0, 5'd0, 5'd3, 1'b0, 1'b1)});
        vecs.push_back('{enc_i(12'hFFF, 5'd1, 3'd0, 5'd2, OPIMM), 32'h0, 32'd20, 32'd0, 1'b0, 5'd0, 32'd0,
                         mkb(32'd20, 32'hFFFF_FFFF, 5'd1, 5'd2, 1'b1, 1'b0)});
        vecs.push_back('{enc_b(5'd2, 5'd1, 3'd2), 32'h0, 32'd5, 32'd7, 1'b0, 5'd0, 32'd0,
                         mkb(32'd0, 32'd0, 5'd0, 5'd0, 1'b0, 1'b1)});
        vecs.push_back('{enc_i(12'h800, 5'd1, 3'd3, 5'd3, OPIMM), 32'h0, 32'd4, 32'd0, 1'b0, 5'd0, 32'd0,
                         mkb(32'd4, 32'hFFFF_F800, 5'd7, 5'd3, 1'b1, 1'b0)});
        vecs.push_back('{enc_r(7'h20, 5'd2, 5'd1, 3'd5, 5'd5, OP), 32'h0, 32'd8, 32'd1, 1'b0, 5'd0, 32'd0,
                         mkb(32'd8, 32'd1, 5'd14, 5'd5, 1'b1, 1'b0)});
        vecs.push_back('{enc_r(7'h00, 5'd7, 5'd1, 3'd0, 5'd6, OP), 32'h0, 32'd3, 32'd4, 1'b0, 5'd7, 32'd9,
                         mkb(32'd3, 32'd4, 5'd1, 5'd6, 1'b1, 1'b0)});

        // Reset, then three idle cycles.
        rst_n = 1'b0;
        applyStimulus(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
        repeat (2) @(negedge clk);
        checkOutput('0, "in_reset");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput('0, "reset_idle");
        checkScalar("ready_idle", 32'(id_ready_o), 32'd1);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].inst, vecs[i].pc, 1'b1, 1'b0, 1'b0, vecs[i].rs1d, vecs[i].rs2d,
                          vecs[i].fwe, vecs[i].fwa, vecs[i].fwd);
            #1;
            checkScalar($sformatf("raddr%0d", i), 32'({rs1_raddr_o, rs2_raddr_o}),
                        32'({vecs[i].inst[19:15], vecs[i].inst[24:20]}));
            @(negedge clk);
            checkOutput(vecs[i].exp, $sformatf("vec%0d", i));
        end

        // Stall holds the captured add while an xor waits upstream.
        add_b = vecs[0].exp;
        applyStimulus(vecs[0].inst, 32'h0, 1'b1, 1'b0, 1'b0, 32'd5, 32'd7, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        checkOutput(add_b, "stall_capture");
        applyStimulus(enc_r(7'h00, 5'd2, 5'd1, 3'd4, 5'd8, OP), 32'h0, 1'b1, 1'b1, 1'b0,
                      32'd11, 32'd22, 1'b1, 5'd1, 32'd33);
        #1;
        checkScalar("ready_stall", 32'(id_ready_o), 32'd0);
        @(negedge clk);
        checkOutput(add_b, "stall_hold1");
        @(negedge clk);
        checkOutput(add_b, "stall_hold2");
        flush_i = 1'b1;
        @(negedge clk);
        checkOutput('0, "stall_flush");

        // Bubble after a capture.
        applyStimulus(vecs[0].inst, 32'h0, 1'b1, 1'b0, 1'b0, 32'd5, 32'd7, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        checkOutput(add_b, "bubble_capture");
        if_valid_i = 1'b0;
        @(negedge clk);
        checkOutput('0, "bubble");

        // Asynchronous reset in the middle of a stall.
        applyStimulus(vecs[0].inst, 32'h0, 1'b1, 1'b0, 1'b0, 32'd5, 32'd7, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        stall_i = 1'b1;
        @(negedge clk);
        checkOutput(add_b, "async_pre");
        #2 rst_n = 1'b0;
        #1;
        checkOutput('0, "async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
        exp_q = '0;

        // Random instructions with random valid/stall/flush against the reference model.
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            checkOutput(exp_q, $sformatf("rand%0d", i));
            genRandom(g_inst, g_pc, g_rs1d, g_rs2d, g_fwe, g_fwa, g_fwd, cap);
            g_v  = ($urandom_range(0, 5) != 0);
            g_st = ($urandom_range(0, 4) == 0);
            g_fl = ($urandom_range(0, 7) == 0);
            applyStimulus(g_inst, g_pc, g_v, g_st, g_fl, g_rs1d, g_rs2d, g_fwe, g_fwa, g_fwd);
            #1;
            checkScalar($sformatf("rand_ready%0d", i), 32'(id_ready_o), 32'(!g_st));
            if (g_fl)
                exp_q = '0;
            else if (!g_st)
                exp_q = g_v ? cap : '0;
        end
        @(negedge clk);
        checkOutput(exp_q, "rand_final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/id_issue_stage.md
Name: id_issue_stage

Overview:
- Decode stage feeding the execute stage; produces the id_ex_reg_* bundle the ALU consumes.
- Decodes RV32I OP, OP-IMM, LUI, AUIPC and BRANCH instructions into an ALU control code, operands, a destination register and a write enable.
- Reads the register file through external read ports and forwards a pending writeback result.
- Registers the bundle in the ID/EX pipeline register, with a valid bit, stall and flush.

Parameters:
- XLEN, 32, operand/data width
- RESET_PC, 32'h0000_0000, reserved; no internal use (PC comes from fetch)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- if_inst_i  in  32  instruction from fetch
- if_pc_i  in  32  PC of if_inst_i
- if_valid_i  in  1  if_inst_i/if_pc_i valid this cycle
- id_ready_o  out  1  stage accepts an instruction this cycle
- stall_i  in  1  hold the ID/EX register
- flush_i  in  1  kill the instruction being captured
- rs1_raddr_o  out  5  regfile read address 1 (combinational, inst[19:15])
- rs2_raddr_o  out  5  regfile read address 2 (combinational, inst[24:20])
- rs1_rdata_i  in  32  regfile read data 1
- rs2_rdata_i  in  32  regfile read data 2
- fwd_we_i  in  1  writeback in flight
- fwd_waddr_i  in  5  writeback destination
- fwd_wdata_i  in  32  writeback data
- id_ex_reg_op_a_o  out  32  ALU operand A
- id_ex_reg_op_b_o  out  32  ALU operand B
- id_ex_reg_ALUctrl_o  out  5  ALU control code
- id_ex_reg_reg_waddr_o  out  5  destination register
- id_ex_reg_reg_we_o  out  1  register write enable
- id_ex_valid_o  out  1  bundle valid
- illegal_inst_o  out  1  captured instruction was illegal (registered)

Behaviour:
- ALU codes, 5-bit: NO_OP=0, ADD=1, SUB=2, EQU=3, NEQ=4, SLT=5, SGE=6, SLTU=7, SGEU=8, XOR=9, OR=10, AND=11, SLL=12, SRL=13, SRA=14.
- Reset: all registered outputs are 0, so ALUctrl=NO_OP, we=0, valid=0, illegal=0.
- Operand fetch: operand from register x0 is always 0.
- Forwarding: else if fwd_we_i && fwd_waddr_i==rs, the operand is fwd_wdata_i. Otherwise it is rs*_rdata_i.
- OP (7'b0110011):
  - funct7=0: f3 0 ADD, 1 SLL, 2 SLT, 3 SLTU, 4 XOR, 5 SRL, 6 OR, 7 AND.
  - funct7=7'h20: f3 0 SUB, f3 5 SRA.
  - Any other funct7: illegal.
  - a=rs1, b=rs2, we=1.
- OP-IMM (7'b0010011):
  - Same f3 map; f3 0 is always ADD.
  - b = sign-extended inst[31:20].
  - f3 1 requires inst[31:25]=0.
  - f3 5: inst[31:25]=0 gives SRL, 7'h20 gives SRA, anything else is illegal.
  - b for shifts is zero-extended inst[24:20].
  - a=rs1, we=1.
- LUI: a=0, b={inst[31:12],12'h0}, ADD, we=1.
- AUIPC: a=if_pc_i, b={inst[31:12],12'h0}, ADD, we=1.
- BRANCH (7'b1100011):
  - f3 0 EQU, 1 NEQ, 4 SLT, 5 SGE, 6 SLTU, 7 SGEU.
  - f3 2 and 3 are illegal.
  - a=rs1, b=rs2, we=0.
- Any other opcode is illegal.
- Illegal instruction: ALUctrl=NO_OP, a=b=0, we=0, illegal_inst_o=1 when captured.
- Destination: waddr = inst[11:7]. we forced 0 when waddr=0.
- id_ready_o = !stall_i (combinational).
- Register update priority, each rising edge:
  1. flush_i: valid=0, we=0, ALUctrl=NO_OP, a=b=0, waddr=0, illegal=0. Flush overrides stall.
  2. stall_i: all registered outputs hold.
  3. !if_valid_i: bubble, same values as flush.
  4. Otherwise: capture the decoded bundle, valid=1.
- Latency: one cycle from an accepted instruction to the bundle at the outputs.
- Forwarding is sampled in the capture cycle only. While stalled, held operands are not re-forwarded; the upstream hazard unit guarantees this is safe.
- Async reset mid-stall or mid-capture returns every output to its reset value immediately.

Test Plan:
- Reset released, if_valid_i=0 for 3 cycles -> all outputs 0, id_ready_o=1.
- `add x3,x1,x2` with rs1_rdata=5, rs2_rdata=7 -> next cycle op_a=5, op_b=7, ALUctrl=1, waddr=3, we=1, valid=1. `sub` (funct7=7'h20) -> ALUctrl=2. `srai x4,x4,3` with rs1_rdata=32'hF0000000 -> ALUctrl=14, op_b=3.
- `lui x5,0x12345` -> op_a=0, op_b=32'h12345000, ADD, we=1. `auipc` at pc=32'h100 with imm 1 -> op_a=32'h100, op_b=32'h1000.
- `bge x1,x2`, rs1_rdata=-1, rs2_rdata=1 -> ALUctrl=6, we=0. `addi x0,x1,1` -> we=0.
- Forwarding: `add x6,x7,x7`, rs1_rdata=1, fwd_we=1, fwd_waddr=7, fwd_wdata=9 -> op_a=op_b=9. Same with fwd_waddr=0 for `add x6,x0,x0` -> operands 0.
- Hazard controls and illegal decode:
  - Capture `add`, then stall_i=1 for 2 cycles while feeding `xor` -> outputs hold the `add` bundle, id_ready_o=0.
  - stall_i=1 and flush_i=1 together -> valid=0, ALUctrl=0 next cycle.
  - Opcode 7'b0000000 -> illegal_inst_o=1, we=0, ALUctrl=0.
